// File: rtl/spi_pkg.sv
// Shared widths, read/write encoding and controller state encoding for the
// spiMemory SPI initiator.
package spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

endpackage

// File: rtl/spi_sclk_divider.sv
// Half-period timer for sclk. The FSM interprets the strobes according to its
// state; rise/fall only say which way sclk moves when a half-period ends.
module spi_sclk_divider #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic sclk_level_i,
    output logic half_tick_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        half_tick_o = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
        rise_tick_o = half_tick_o && !sclk_level_i;
        fall_tick_o = half_tick_o && sclk_level_i;
        // Held at zero while disabled so every enabled stretch starts a full half-period.
        if (!en_i || half_tick_o) cnt_d = '0;
        else                      cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: asynchronous reset only touches this counter; no memory arrays need clearing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_memory_master.sv
// SPI mode-0 initiator: one 16-bit {addr, rw, data} frame per accepted command,
// with read data captured from miso during the data byte.
module spi_memory_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 5,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);
    // The IDLE clk before a back-to-back acceptance completes the chip-select gap.
    localparam int GAP_CLKS = CS_GAP * CLK_DIV - 1;
    localparam int GAP_W    = $clog2(GAP_CLKS + 1);
    localparam int BIT_W    = $clog2(FRAME_BITS);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [DATA_W-1:0]     rx_q, rx_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  rw_q, rw_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_q, cs_d;
    logic                  rvalid_q, rvalid_d;
    logic                  miso_s1_q, miso_s2_q;
    logic                  div_en, half_tick, rise_tick, fall_tick;

    assign div_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    spi_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk          (clk),
        .reset_n      (reset_n),
        .en_i         (div_en),
        .sclk_level_i (sclk_q),
        .half_tick_o  (half_tick),
        .rise_tick_o  (rise_tick),
        .fall_tick_o  (fall_tick)
    );

    assign cmd_ready = (state_q == IDLE) && reset_n;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign sclk_pin  = sclk_q;
    assign cs_pin    = cs_q;
    assign mosi_pin  = sreg_q[FRAME_BITS-1];

    always_comb begin
        // NOTE: every _d starts from its _q so no branch below can infer a latch.
        state_d  = state_q;
        sreg_d   = sreg_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        rw_d     = rw_q;
        sclk_d   = sclk_q;
        cs_d     = cs_q;
        rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    sreg_d  = {cmd_addr, cmd_rw,
                               (cmd_rw == RW_READ) ? {DATA_W{1'b0}} : cmd_wdata};
                    rw_d    = cmd_rw;
                    rx_d    = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (rise_tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_tick) begin
                    sclk_d = 1'b0;
                    sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_q >= BIT_W'(ADDR_W + 1)) rx_d = {rx_q[DATA_W-2:0], miso_s2_q};
                end else if (rise_tick) begin
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    cs_d     = 1'b1;
                    rvalid_d = 1'b1;
                    rdata_d  = (rw_q == RW_READ) ? rx_q : '0;
                    gap_d    = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CLKS - 1)) state_d = IDLE;
                else                               gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            rw_q      <= RW_WRITE;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            rvalid_q  <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            rw_q      <= rw_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            rvalid_q  <= rvalid_d;
            miso_s1_q <= miso_pin;
            miso_s2_q <= miso_s1_q;
        end
    end

endmodule
